// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: ID->EX pipeline register with stall/flush, precise exception capture and stall counter.
module id_ex_pipe_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int CTRL_W    = 8,
    parameter int CAUSE_W   = 2,
    parameter int INSTR_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_pc_plus4,
    input  logic [DATA_W-1:0]  in_rd1,
    input  logic [DATA_W-1:0]  in_rd2,
    input  logic [DATA_W-1:0]  in_imm,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rt,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic               in_exc,
    input  logic [CAUSE_W-1:0] in_cause,
    input  logic               stall,
    input  logic               flush,
    input  logic               exc_ack,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_pc_plus4,
    output logic [DATA_W-1:0]  out_rd1,
    output logic [DATA_W-1:0]  out_rd2,
    output logic [DATA_W-1:0]  out_imm,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic [REG_W-1:0]   out_rd,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               exc_pending,
    output logic [CNT_W-1:0]   stall_cnt
);
    typedef enum logic {IDLE, PENDING} state_e;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REG_W-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [DATA_W-1:0]  epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load, cap;

    always_comb begin
        load    = !flush && !stall;
        cap     = load && in_valid && in_exc;
        valid_d = valid_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            ctrl_d  = '0;
        end else if (load) begin
            // a faulting instruction is squashed so it never reaches EX
            valid_d = in_valid && !in_exc;
            pc_d    = in_pc_plus4;
            rd1_d   = in_rd1;
            rd2_d   = in_rd2;
            imm_d   = in_imm;
            rs_d    = in_rs;
            rt_d    = in_rt;
            rd_d    = in_rd;
            ctrl_d  = (in_valid && !in_exc) ? in_ctrl : '0;
        end
        cnt_d = (stall && !flush && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        if (cap && (state_q == IDLE || exc_ack)) begin
            state_d = PENDING;
            epc_d   = in_pc_plus4 - DATA_W'(INSTR_LEN);
            cause_d = in_cause;
        end else if (exc_ack) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            epc_q   <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc_plus4 = pc_q;
    assign out_rd1      = rd1_q;
    assign out_rd2      = rd2_q;
    assign out_imm      = imm_q;
    assign out_rs       = rs_q;
    assign out_rt       = rt_q;
    assign out_rd       = rd_q;
    assign out_ctrl     = ctrl_q;
    assign epc          = epc_q;
    assign cause        = cause_q;
    assign exc_pending  = (state_q == PENDING);
    assign stall_cnt    = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// tb_id_ex_pipe_stage: directed and random stimulus against a behavioural model of the ID/EX stage.
module tb_id_ex_pipe_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid, in_exc, stall, flush, exc_ack;
    logic [31:0] in_pc_plus4, in_rd1, in_rd2, in_imm;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [7:0]  in_ctrl;
    logic [1:0]  in_cause;
    logic        out_valid, exc_pending;
    logic [31:0] out_pc_plus4, out_rd1, out_rd2, out_imm, epc;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [7:0]  out_ctrl;
    logic [1:0]  cause;
    logic [15:0] stall_cnt;
    logic        d2_out_valid, d2_exc_pending;
    logic [31:0] d2_out_pc_plus4, d2_out_rd1, d2_out_rd2, d2_out_imm, d2_epc;
    logic [4:0]  d2_out_rs, d2_out_rt, d2_out_rd;
    logic [7:0]  d2_out_ctrl;
    logic [1:0]  d2_cause;
    logic [1:0]  d2_stall_cnt;

    int checks = 0, failures = 0;

    logic        m_valid, m_pend;
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm, m_epc;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [7:0]  m_ctrl;
    logic [1:0]  m_cause;
    int          m_cnt, m_cnt2;

    always #5 clk = ~clk;

    id_ex_pipe_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc_plus4(in_pc_plus4),
        .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_ctrl(in_ctrl), .in_exc(in_exc), .in_cause(in_cause),
        .stall(stall), .flush(flush), .exc_ack(exc_ack), .out_valid(out_valid),
        .out_pc_plus4(out_pc_plus4), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_ctrl(out_ctrl),
        .epc(epc), .cause(cause), .exc_pending(exc_pending), .stall_cnt(stall_cnt)
    );

    id_ex_pipe_stage #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc_plus4(in_pc_plus4),
        .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_ctrl(in_ctrl), .in_exc(in_exc), .in_cause(in_cause),
        .stall(stall), .flush(flush), .exc_ack(exc_ack), .out_valid(d2_out_valid),
        .out_pc_plus4(d2_out_pc_plus4), .out_rd1(d2_out_rd1), .out_rd2(d2_out_rd2), .out_imm(d2_out_imm),
        .out_rs(d2_out_rs), .out_rt(d2_out_rt), .out_rd(d2_out_rd), .out_ctrl(d2_out_ctrl),
        .epc(d2_epc), .cause(d2_cause), .exc_pending(d2_exc_pending), .stall_cnt(d2_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        {m_valid, m_pend, m_pc, m_rd1, m_rd2, m_imm, m_epc, m_rs, m_rt, m_rd, m_ctrl, m_cause} = '0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".pc"},    64'(out_pc_plus4), 64'(m_pc));
        chk({tag, ".rd1"},   64'(out_rd1), 64'(m_rd1));
        chk({tag, ".rd2"},   64'(out_rd2), 64'(m_rd2));
        chk({tag, ".imm"},   64'(out_imm), 64'(m_imm));
        chk({tag, ".regs"},  64'({out_rs, out_rt, out_rd}), 64'({m_rs, m_rt, m_rd}));
        chk({tag, ".ctrl"},  64'(out_ctrl), 64'(m_ctrl));
        chk({tag, ".epc"},   64'(epc), 64'(m_epc));
        chk({tag, ".cause"}, 64'(cause), 64'(m_cause));
        chk({tag, ".pend"},  64'(exc_pending), 64'(m_pend));
        chk({tag, ".cnt"},   64'(stall_cnt), 64'(m_cnt));
        chk({tag, ".cnt2"},  64'(d2_stall_cnt), 64'(m_cnt2));
        chk({tag, ".d2"},    64'({d2_out_valid, d2_exc_pending, d2_epc}), 64'({m_valid, m_pend, m_epc}));
    endtask

    task automatic step(input string tag);
        logic take;
        @(posedge clk);
        if (rst) m_reset();
        else if (flush) begin
            {m_valid, m_pc, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd, m_ctrl} = '0;
        end else if (stall) begin
            m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
        end else begin
            m_valid = in_valid && !in_exc;
            {m_pc, m_rd1, m_rd2, m_imm} = {in_pc_plus4, in_rd1, in_rd2, in_imm};
            {m_rs, m_rt, m_rd} = {in_rs, in_rt, in_rd};
            m_ctrl = m_valid ? in_ctrl : 8'h00;
        end
        if (!rst) begin
            take = !flush && !stall && in_valid && in_exc && (!m_pend || exc_ack);
            if (take) begin
                m_epc   = in_pc_plus4 - 32'd4;
                m_cause = in_cause;
                m_pend  = 1'b1;
            end else if (exc_ack) m_pend = 1'b0;
        end
        #1;
        cmp_all(tag);
    endtask

    task automatic idle_in();
        {in_valid, in_exc, stall, flush, exc_ack, in_cause, in_ctrl} = '0;
        {in_pc_plus4, in_rd1, in_rd2, in_imm, in_rs, in_rt, in_rd} = '0;
    endtask

    initial begin
        int exp2 [6] = '{1, 2, 3, 3, 3, 3};
        idle_in();
        m_reset();
        step("reset");
        step("reset2");
        rst = 1'b0;
        in_valid = 1'b1; in_rd1 = 32'h1234_5678; in_ctrl = 8'hA5; in_rs = 5'd3; in_pc_plus4 = 32'h100;
        step("load");
        chk("load.rd1", 64'(out_rd1), 64'h1234_5678);
        chk("load.ctrl", 64'(out_ctrl), 64'hA5);
        chk("load.valid", 64'(out_valid), 64'd1);
        in_rd1 = 32'hDEAD_BEEF; in_ctrl = 8'h11; stall = 1'b1;
        repeat (3) step("stall");
        chk("stall.rd1", 64'(out_rd1), 64'h1234_5678);
        chk("stall.cnt", 64'(stall_cnt), 64'd3);
        flush = 1'b1;
        step("flush");
        chk("flush.valid", 64'(out_valid), 64'd0);
        chk("flush.ctrl", 64'(out_ctrl), 64'd0);
        chk("flush.cnt", 64'(stall_cnt), 64'd3);
        idle_in();
        in_valid = 1'b1; in_exc = 1'b1; in_cause = 2'd1; in_pc_plus4 = 32'h0040_0010; in_ctrl = 8'hFF;
        step("exc");
        chk("exc.epc", 64'(epc), 64'h0040_000C);
        chk("exc.cause", 64'(cause), 64'd1);
        chk("exc.pend", 64'(exc_pending), 64'd1);
        chk("exc.valid", 64'(out_valid), 64'd0);
        in_pc_plus4 = 32'h0040_0020; in_cause = 2'd2;
        step("exc2");
        chk("exc2.epc", 64'(epc), 64'h0040_000C);
        in_exc = 1'b0; exc_ack = 1'b1;
        step("ack");
        chk("ack.pend", 64'(exc_pending), 64'd0);
        chk("ack.epc", 64'(epc), 64'h0040_000C);
        exc_ack = 1'b0; in_exc = 1'b1; in_cause = 2'd3; in_pc_plus4 = 32'h0000_0100;
        step("exc3");
        exc_ack = 1'b1; in_cause = 2'd2; in_pc_plus4 = 32'h0000_0004;
        step("ackexc");
        chk("ackexc.epc", 64'(epc), 64'h0);
        chk("ackexc.cause", 64'(cause), 64'd2);
        chk("ackexc.pend", 64'(exc_pending), 64'd1);
        idle_in();
        rst = 1'b1;
        step("rst6");
        rst = 1'b0; stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("sat");
            chk($sformatf("sat%0d", i), 64'(d2_stall_cnt), 64'(exp2[i]));
        end
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 4) != 0;
            in_exc = ($urandom % 6) == 0;
            stall = ($urandom % 5) == 0;
            flush = ($urandom % 7) == 0;
            exc_ack = ($urandom % 4) == 0;
            in_cause = 2'($urandom);
            in_ctrl = 8'($urandom);
            {in_rs, in_rt, in_rd} = 15'($urandom);
            in_pc_plus4 = ($urandom % 8 == 0) ? 32'($urandom % 4) : $urandom;
            {in_rd1, in_rd2, in_imm} = {$urandom, $urandom, $urandom};
            step("rand");
        end
        idle_in();
        in_valid = 1'b1; in_exc = 1'b1; in_pc_plus4 = 32'h200; in_cause = 2'd1;
        step("pre1");
        in_exc = 1'b0; in_ctrl = 8'h3C; in_rd2 = 32'h55;
        step("pre2");
        chk("pre.valid", 64'(out_valid), 64'd1);
        chk("pre.pend", 64'(exc_pending), 64'd1);
        #3 rst = 1'b1;
        #1 m_reset();
        cmp_all("arst");
        chk("arst.valid", 64'(out_valid), 64'd0);
        chk("arst.pend", 64'(exc_pending), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
